// File: rtl/id_ex_pkg.sv
// id_ex_pkg: ALU control and ALUOp encodings shared by the ID/EX stage and its decoder.
package id_ex_pkg;
  localparam int ALU_CTRL_W = 4;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR = 4'b0011;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL = 4'b0100;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA = 4'b0101;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALU_CTRL_W-1:0] ALU_MUL = 4'b1111;
  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;
endpackage

// File: rtl/id_ex_stage_alu_ctrl_dec.sv
// alu_ctrl_dec: combinational ALUOp/funct decoder; undecodable combinations yield ADD with illegal set.
module alu_ctrl_dec
  import id_ex_pkg::*;
(
  input  logic [1:0]            alu_op_i,
  input  logic [2:0]            funct3_i,
  input  logic [6:0]            funct7_i,
  output logic [ALU_CTRL_W-1:0] alu_ctrl_o,
  output logic                  illegal_o
);
  logic [9:0] f;
  assign f = {funct7_i, funct3_i};
  always_comb begin
    alu_ctrl_o = ALU_ADD;
    illegal_o  = 1'b0;
    case (alu_op_i)
      ALUOP_ADD: alu_ctrl_o = ALU_ADD;
      ALUOP_SUB: alu_ctrl_o = ALU_SUB;
      ALUOP_R: begin
        case (f)
          10'h000: alu_ctrl_o = ALU_ADD;
          10'h100: alu_ctrl_o = ALU_SUB;
          10'h007: alu_ctrl_o = ALU_AND;
          10'h006: alu_ctrl_o = ALU_OR;
          10'h004: alu_ctrl_o = ALU_XOR;
          10'h001: alu_ctrl_o = ALU_SLL;
          10'h105: alu_ctrl_o = ALU_SRA;
          10'h008: alu_ctrl_o = ALU_MUL;
          default: illegal_o  = 1'b1;
        endcase
      end
      default: begin
        case (funct3_i)
          3'b000:  alu_ctrl_o = ALU_ADD;
          3'b111:  alu_ctrl_o = ALU_AND;
          3'b110:  alu_ctrl_o = ALU_OR;
          3'b100:  alu_ctrl_o = ALU_XOR;
          3'b001:  alu_ctrl_o = ALU_SLL;
          3'b101: begin
            alu_ctrl_o = (funct7_i == 7'h20) ? ALU_SRA : ALU_ADD;
            illegal_o  = (funct7_i != 7'h20);
          end
          default: illegal_o = 1'b1;
        endcase
      end
    endcase
  end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with stall/flush, valid bit and ALU control decode.
// Defining ID_EX_PERF_EN adds stall and bubble performance counters.
module id_ex_stage
  import id_ex_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
`ifdef ID_EX_PERF_EN
  ,
  parameter int CNT_W  = 32
`endif
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  input  logic [XLEN-1:0]       rs1_data_i,
  input  logic [XLEN-1:0]       rs2_data_i,
  input  logic [XLEN-1:0]       imm_i,
  input  logic [REG_AW-1:0]     rs1_addr_i,
  input  logic [REG_AW-1:0]     rs2_addr_i,
  input  logic [REG_AW-1:0]     rd_addr_i,
  input  logic [2:0]            funct3_i,
  input  logic [6:0]            funct7_i,
  input  logic                  wb_i,
  input  logic [1:0]            mem_i,
  input  logic [1:0]            alu_op_i,
  input  logic                  alu_src_i,
  output logic                  valid_o,
  output logic [XLEN-1:0]       rs1_data_o,
  output logic [XLEN-1:0]       rs2_data_o,
  output logic [XLEN-1:0]       imm_o,
  output logic [REG_AW-1:0]     rs1_addr_o,
  output logic [REG_AW-1:0]     rs2_addr_o,
  output logic [REG_AW-1:0]     rd_addr_o,
  output logic                  wb_o,
  output logic [1:0]            mem_o,
  output logic                  alu_src_o,
  output logic [ALU_CTRL_W-1:0] alu_ctrl_o,
  output logic                  illegal_o
`ifdef ID_EX_PERF_EN
  ,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      bubble_cnt_o
`endif
);
  logic [ALU_CTRL_W-1:0] dec_ctrl, alu_ctrl_d, alu_ctrl_q;
  logic dec_ill, load, bub;
  logic valid_d, valid_q, wb_d, wb_q, alu_src_d, alu_src_q, illegal_d, illegal_q;
  logic [XLEN-1:0] rs1_data_d, rs1_data_q, rs2_data_d, rs2_data_q, imm_d, imm_q;
  logic [REG_AW-1:0] rs1_addr_d, rs1_addr_q, rs2_addr_d, rs2_addr_q, rd_addr_d, rd_addr_q;
  logic [1:0] mem_d, mem_q;
  alu_ctrl_dec u_dec (
    .alu_op_i  (alu_op_i),
    .funct3_i  (funct3_i),
    .funct7_i  (funct7_i),
    .alu_ctrl_o(dec_ctrl),
    .illegal_o (dec_ill)
  );
  // A bubble is the reset image; flush overrides stall.
  always_comb begin
    load       = ~stall_i | flush_i;
    bub        = flush_i | ~valid_i;
    valid_d    = load ? ~bub : valid_q;
    rs1_data_d = load ? (bub ? '0 : rs1_data_i) : rs1_data_q;
    rs2_data_d = load ? (bub ? '0 : rs2_data_i) : rs2_data_q;
    imm_d      = load ? (bub ? '0 : imm_i) : imm_q;
    rs1_addr_d = load ? (bub ? '0 : rs1_addr_i) : rs1_addr_q;
    rs2_addr_d = load ? (bub ? '0 : rs2_addr_i) : rs2_addr_q;
    rd_addr_d  = load ? (bub ? '0 : rd_addr_i) : rd_addr_q;
    wb_d       = load ? (~bub & wb_i & (rd_addr_i != '0)) : wb_q;
    mem_d      = load ? (bub ? 2'b00 : mem_i) : mem_q;
    alu_src_d  = load ? (~bub & alu_src_i) : alu_src_q;
    alu_ctrl_d = load ? (bub ? ALU_ADD : dec_ctrl) : alu_ctrl_q;
    illegal_d  = load ? (~bub & dec_ill) : illegal_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q    <= 1'b0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rd_addr_q  <= '0;
      wb_q       <= 1'b0;
      mem_q      <= 2'b00;
      alu_src_q  <= 1'b0;
      alu_ctrl_q <= ALU_ADD;
      illegal_q  <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_addr_q <= rs1_addr_d;
      rs2_addr_q <= rs2_addr_d;
      rd_addr_q  <= rd_addr_d;
      wb_q       <= wb_d;
      mem_q      <= mem_d;
      alu_src_q  <= alu_src_d;
      alu_ctrl_q <= alu_ctrl_d;
      illegal_q  <= illegal_d;
    end
  end
  assign valid_o    = valid_q;
  assign rs1_data_o = rs1_data_q;
  assign rs2_data_o = rs2_data_q;
  assign imm_o      = imm_q;
  assign rs1_addr_o = rs1_addr_q;
  assign rs2_addr_o = rs2_addr_q;
  assign rd_addr_o  = rd_addr_q;
  assign wb_o       = wb_q;
  assign mem_o      = mem_q;
  assign alu_src_o  = alu_src_q;
  assign alu_ctrl_o = alu_ctrl_q;
  assign illegal_o  = illegal_q;
`ifdef ID_EX_PERF_EN
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q, bubble_cnt_d, bubble_cnt_q;
  always_comb begin
    stall_cnt_d  = stall_cnt_q + CNT_W'(stall_i & ~flush_i);
    bubble_cnt_d = bubble_cnt_q + CNT_W'(load & bub);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end
  assign stall_cnt_o  = stall_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;
`endif
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Parametrised successor to the ID/EX pipeline register of the 5-stage RISC-V core, sitting between decode and execute.
- Registers operands, addresses and control fields, and decodes the ALU control code from ALUOp/funct.
- Adds behaviour the previous stage lacked: synchronous reset, hazard-unit stall (hold) and flush (bubble), a valid bit, I-type decode, an illegal-op flag, and rd=x0 write suppression.

Parameters:
- XLEN, 32, operand and immediate width.
- REG_AW, 5, register address width.
- CNT_W, 32, performance counter width (optional feature only).

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- stall_i  in  1  hold all registered outputs.
- flush_i  in  1  load a bubble.
- valid_i  in  1  decode stage holds a real instruction.
- rs1_data_i, rs2_data_i, imm_i  in  XLEN  operands and immediate.
- rs1_addr_i, rs2_addr_i, rd_addr_i  in  REG_AW  register addresses.
- funct3_i  in  3; funct7_i  in  7  instruction function fields.
- wb_i  in  1; mem_i  in  2 ({MemRead,MemWrite}); alu_op_i  in  2; alu_src_i  in  1.
- valid_o  out  1  EX holds a real instruction.
- rs1_data_o, rs2_data_o, imm_o  out  XLEN.
- rs1_addr_o, rs2_addr_o, rd_addr_o  out  REG_AW.
- wb_o  out  1; mem_o  out  2; alu_src_o  out  1.
- alu_ctrl_o  out  4  ALU operation code.
- illegal_o  out  1  funct combination not decodable.

Behaviour:
- Update priority each rising edge: rst_i > flush_i > stall_i > load.
- Reset: every output is 0, except alu_ctrl_o = ADD (4'b0010).
- Flush: same values as reset (bubble). Flush wins over a simultaneous stall.
- Stall (no flush): every output holds its value.
- Load with valid_i=0: bubble, identical to flush.
- Load with valid_i=1: all fields registered, latency 1 cycle; valid_o=1.
  - wb_o = wb_i & (rd_addr_i != 0); writes to x0 are never propagated.
- ALU decode (combinational from inputs, registered with the other fields). f = {funct7_i, funct3_i}.
  - alu_op 00 -> ADD 0010.
  - alu_op 01 -> SUB 0110.
  - alu_op 10 (R-type):
    - f=0x000 ADD; 0x100 SUB; 0x007 AND 0000; 0x006 OR 0001.
    - 0x004 XOR 0011; 0x001 SLL 0100; 0x105 SRA 0101; 0x008 MUL 1111.
  - alu_op 11 (I-type), decoded on funct3 only:
    - 000 ADD; 111 AND; 110 OR; 100 XOR; 001 SLL.
    - 101 is SRA only when funct7_i = 0x20.
  - Any other combination: alu_ctrl = ADD and illegal = 1. Otherwise illegal = 0.
  - The decoder never infers a latch; every path assigns both outputs.
- Reset held across a stall: the stage stays in reset values. Stall released: the next edge loads.

Optional Feature:
- Macro: ID_EX_PERF_EN.
- When defined:
  - Adds outputs stall_cnt_o [CNT_W] and bubble_cnt_o [CNT_W].
  - stall_cnt increments on each edge where stall_i=1 and flush_i=0.
  - bubble_cnt increments on each edge where a bubble is loaded (flush_i, or load with valid_i=0).
  - Both clear on rst_i and wrap modulo 2^CNT_W.
- When undefined: ports and logic are absent; the stage is otherwise identical.

Decomposition:
- Package id_ex_pkg holds:
  - ALU control constants: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRA, ALU_MUL.
  - ALUOp codes: ALUOP_ADD, ALUOP_SUB, ALUOP_R, ALUOP_I.
  - Width constant ALU_CTRL_W = 4.
- One sub-module: alu_ctrl_dec, purely combinational (alu_op, funct3, funct7 -> alu_ctrl, illegal). It is instantiated in id_ex_stage and reused by the execute-stage checker.

Test Plan:
- rst_i=1 for 2 cycles with random inputs -> all outputs 0, alu_ctrl_o=0010; release with valid_i=1, alu_op=10, f=0x100 -> next cycle valid_o=1, alu_ctrl_o=0110.
- Load rs1_data=0xDEADBEEF, then stall_i=1 for 3 cycles with changing inputs -> outputs stay 0xDEADBEEF; stall drops -> new value after 1 cycle.
- stall_i=1 and flush_i=1 on the same edge -> valid_o=0, wb_o=0, mem_o=00; with ID_EX_PERF_EN, bubble_cnt +1 and stall_cnt unchanged.
- valid_i=1, wb_i=1, rd_addr=0 -> wb_o=0; rd_addr=5 -> wb_o=1.
- Decode sweep:
  - alu_op=11, funct3=101, funct7=0x20 -> 0101, illegal 0.
  - Same with funct7=0x00 -> 0010, illegal 1.
  - alu_op=10, f=0x008 -> 1111.
  - alu_op=10, f=0x3FF -> 0010, illegal 1.
- ID_EX_PERF_EN with CNT_W=4: 17 stall cycles -> stall_cnt_o=1 (wrap).
